// File: rtl/axi3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi3_pkg
// Description : Shared AXI3 constants, AW payload struct and width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi3_pkg;

    localparam logic [1:0] AXI3_LOCK_NORMAL    = 2'b00;
    localparam logic [1:0] AXI3_LOCK_EXCLUSIVE = 2'b01;
    localparam logic [1:0] AXI3_LOCK_LOCKED    = 2'b10;

    localparam logic [1:0] AXI3_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI3_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI3_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI3_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI3_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI3_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI3_RESP_DECERR = 2'b11;

    localparam int AXI3_ID_W   = 4;
    localparam int AXI3_ADDR_W = 32;

    // Field order fixes the packed layout: lock always sits in bits [1:0].
    typedef struct packed {
        logic [AXI3_ID_W-1:0]   id;
        logic [AXI3_ADDR_W-1:0] addr;
        logic [3:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
        logic [1:0]             lock;
    } axi3_aw_t;

    localparam int AXI3_AW_W = $bits(axi3_aw_t);

    function automatic int axi3_aw_width(input int id_w, input int addr_w);
        return id_w + addr_w + 4 + 3 + 2 + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi3_aw_w_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : axi3_rr_arbiter
// Description : N-way round-robin arbiter; one-hot grant of the first request
//               at or after the pointer, pointer moves past the winner on i_adv.
// Revision    : 1.0 - initial release
// ============================================================================
module axi3_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_en,
    input  logic             i_adv,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic [IDX_W-1:0] o_ptr
);

    logic [IDX_W-1:0] r_ptr_q, w_ptr_d;
    logic [IDX_W-1:0] w_lo, w_hi, w_win;
    logic             w_hi_any;

    // Descending scan so the lowest qualifying index wins in each half.
    always_comb begin
        w_lo     = '0;
        w_hi     = '0;
        w_hi_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo = IDX_W'(i);
                if (i >= int'(r_ptr_q)) begin
                    w_hi     = IDX_W'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
        w_win = w_hi_any ? w_hi : w_lo;
    end

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = i_en && o_any && (w_win == IDX_W'(i));
        end
    end

    always_comb begin
        w_ptr_d = r_ptr_q;
        if (i_en && o_any && i_adv) begin
            w_ptr_d = (w_win == IDX_W'(N - 1)) ? '0 : w_win + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign o_any = |i_req;
    assign o_idx = w_win;
    assign o_ptr = r_ptr_q;

endmodule
`default_nettype wire

// File: rtl/axi3_aw_w_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi3_aw_w_arbiter
// Description : N-to-1 AXI3 write arbiter: round-robin AW, W routed in grant
//               order through an order FIFO, B routed back by ID prefix.
//               Optional macro AXI3_ARB_LOCK_EN pins arbitration on locked AWs.
// Revision    : 1.0 - initial release
// ============================================================================
module axi3_aw_w_arbiter
    import axi3_pkg::*;
#(
    parameter  int N_MST     = 4,
    parameter  int ID_W      = 4,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 64,
    parameter  int ORD_DEPTH = 4,
    localparam int IDX_W     = $clog2(N_MST),
    localparam int AW_W      = axi3_aw_width(ID_W, ADDR_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MST-1:0]           s_awvalid,
    output logic [N_MST-1:0]           s_awready,
    input  logic [N_MST*AW_W-1:0]      s_aw,
    input  logic [N_MST-1:0]           s_wvalid,
    output logic [N_MST-1:0]           s_wready,
    input  logic [N_MST*DATA_W-1:0]    s_wdata,
    input  logic [N_MST*DATA_W/8-1:0]  s_wstrb,
    input  logic [N_MST-1:0]           s_wlast,
    output logic [N_MST-1:0]           s_bvalid,
    input  logic [N_MST-1:0]           s_bready,
    output logic [ID_W-1:0]            s_bid,
    output logic [1:0]                 s_bresp,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [AW_W+IDX_W-1:0]      m_aw,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_wlast,
    input  logic                       m_bvalid,
    output logic                       m_bready,
    input  logic [ID_W+IDX_W-1:0]      m_bid,
    input  logic [1:0]                 m_bresp
);

    localparam int c_PTR_W = $clog2(ORD_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STB_W = DATA_W / 8;

    logic [N_MST-1:0]      w_req, w_gnt;
    logic [IDX_W-1:0]      w_win, w_rr_ptr, w_head, w_bidx;
    logic [AW_W-1:0]       w_win_aw;
    logic                  w_any, w_adv, w_slot_free, w_grant_en, w_push, w_pop;
    logic                  w_fifo_full, w_fifo_empty, w_bidx_ok;

    logic                  r_awvalid_q, w_awvalid_d;
    logic [AW_W+IDX_W-1:0] r_aw_q, w_aw_d;
    logic [IDX_W-1:0]      r_ord_mem_q [ORD_DEPTH];
    logic [IDX_W-1:0]      w_ord_mem_d [ORD_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr_q, w_wr_ptr_d, r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]    r_cnt_q, w_cnt_d;

    assign w_win_aw = s_aw[int'(w_win)*AW_W +: AW_W];

`ifdef AXI3_ARB_LOCK_EN
    logic             r_pinned_q, w_pinned_d;
    logic [IDX_W-1:0] r_pin_idx_q, w_pin_idx_d;

    always_comb begin
        w_req       = s_awvalid;
        w_adv       = !r_pinned_q;
        w_pinned_d  = r_pinned_q;
        w_pin_idx_d = r_pin_idx_q;
        if (r_pinned_q) begin
            w_req              = '0;
            w_req[r_pin_idx_q] = s_awvalid[r_pin_idx_q];
        end
        if (w_push) begin
            w_pinned_d  = (w_win_aw[1:0] == AXI3_LOCK_LOCKED);
            w_pin_idx_d = w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pinned_q  <= 1'b0;
            r_pin_idx_q <= '0;
        end else begin
            r_pinned_q  <= w_pinned_d;
            r_pin_idx_q <= w_pin_idx_d;
        end
    end
`else
    assign w_req = s_awvalid;
    assign w_adv = 1'b1;
`endif

    axi3_rr_arbiter #(
        .N (N_MST)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .i_en  (w_grant_en),
        .i_adv (w_adv),
        .o_gnt (w_gnt),
        .o_idx (w_win),
        .o_any (w_any),
        .o_ptr (w_rr_ptr)
    );

    // Grant only sees the registered count, so a pop frees a slot next cycle.
    assign w_slot_free  = !r_awvalid_q || m_awready;
    assign w_fifo_full  = (r_cnt_q == c_CNT_W'(ORD_DEPTH));
    assign w_fifo_empty = (r_cnt_q == '0);
    assign w_grant_en   = !rst && w_slot_free && !w_fifo_full;
    assign w_push       = w_grant_en && w_any;
    assign s_awready    = w_gnt;

    always_comb begin
        w_awvalid_d = r_awvalid_q;
        w_aw_d      = r_aw_q;
        if (w_push) begin
            w_awvalid_d = 1'b1;
            w_aw_d      = {w_win, w_win_aw};
        end else if (m_awready) begin
            w_awvalid_d = 1'b0;
        end
    end

    assign w_head = r_ord_mem_q[r_rd_ptr_q];

    always_comb begin
        m_wvalid = 1'b0;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_wlast  = 1'b0;
        s_wready = '0;
        if (!rst && !w_fifo_empty) begin
            m_wvalid         = s_wvalid[w_head];
            m_wdata          = s_wdata[int'(w_head)*DATA_W +: DATA_W];
            m_wstrb          = s_wstrb[int'(w_head)*c_STB_W +: c_STB_W];
            m_wlast          = s_wlast[w_head];
            s_wready[w_head] = m_wready;
        end
    end

    assign w_pop = m_wvalid && m_wready && m_wlast;

    always_comb begin
        w_ord_mem_d = r_ord_mem_q;
        w_wr_ptr_d  = r_wr_ptr_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_cnt_d     = r_cnt_q;
        if (w_push) begin
            w_ord_mem_d[r_wr_ptr_q] = w_win;
            w_wr_ptr_d              = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_d = r_cnt_q + c_CNT_W'(1);
            2'b01:   w_cnt_d = r_cnt_q - c_CNT_W'(1);
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awvalid_q <= 1'b0;
            r_aw_q      <= '0;
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_cnt_q     <= '0;
            for (int i = 0; i < ORD_DEPTH; i++) begin
                r_ord_mem_q[i] <= '0;
            end
        end else begin
            r_awvalid_q <= w_awvalid_d;
            r_aw_q      <= w_aw_d;
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_cnt_q     <= w_cnt_d;
            r_ord_mem_q <= w_ord_mem_d;
        end
    end

    assign m_awvalid = r_awvalid_q;
    assign m_aw      = r_aw_q;

    // Responses carrying an index with no master behind it are absorbed.
    assign w_bidx    = m_bid[ID_W+IDX_W-1 -: IDX_W];
    assign w_bidx_ok = ({1'b0, w_bidx} < (IDX_W + 1)'(N_MST));

    always_comb begin
        s_bvalid = '0;
        m_bready = 1'b1;
        if (w_bidx_ok) begin
            s_bvalid[w_bidx] = m_bvalid;
            m_bready         = s_bready[w_bidx];
        end
    end

    assign s_bid   = m_bid[ID_W-1:0];
    assign s_bresp = m_bresp;

    a_bidx_in_range: assert property (@(posedge clk) disable iff (rst) m_bvalid |-> w_bidx_ok);

endmodule
`default_nettype wire

// File: tb/tb_axi3_aw_w_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi3_aw_w_arbiter
// Description : Scoreboard bench for axi3_aw_w_arbiter (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi3_aw_w_arbiter;
    import axi3_pkg::*;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int DW    = 64;
    localparam int AWW   = axi3_aw_width(4, 32);
    localparam int WB    = 1 + DW/8 + DW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic [N-1:0]         s_bvalid, s_bready;
    logic [N*AWW-1:0]     s_aw;
    logic [N*DW-1:0]      s_wdata;
    logic [N*DW/8-1:0]    s_wstrb;
    logic [3:0]           s_bid;
    logic [1:0]           s_bresp, m_bresp;
    logic                 m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic                 m_bvalid, m_bready;
    logic [AWW+IDX_W-1:0] m_aw;
    logic [DW-1:0]        m_wdata;
    logic [DW/8-1:0]      m_wstrb;
    logic [5:0]           m_bid;

    axi3_aw_w_arbiter dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int w_seen  = 0;

    logic [AWW-1:0]       aw_q [N][$];
    logic [WB-1:0]        w_q  [N][$];
    logic [AWW+IDX_W-1:0] exp_aw [$];
    logic [WB-1:0]        exp_w  [$];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [AWW-1:0] mk_aw(input logic [3:0] id, input logic [31:0] addr,
                                             input logic [3:0] len);
        return {id, addr, len, 3'd3, AXI3_BURST_INCR, AXI3_LOCK_NORMAL};
    endfunction

    function automatic logic [WB-1:0] mk_w(input logic [DW-1:0] data, input logic last);
        return {last, data[7:0], data};
    endfunction

    function automatic int pending();
        int s;
        s = exp_aw.size() + exp_w.size();
        for (int i = 0; i < N; i++) s += aw_q[i].size() + w_q[i].size();
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (pending() == 0) break;
            tick();
        end
        check("drain", pending(), 0);
    endtask

    // Upstream masters and downstream monitor: sample at negedge, update after posedge.
    initial begin
        logic [N-1:0]   hs_aw, hs_w;
        logic [WB-1:0]  wb;
        logic [WB-1:0]  got_w;
        s_awvalid = '0; s_aw = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
        forever begin
            @(negedge clk);
            hs_aw = s_awvalid & s_awready;
            hs_w  = s_wvalid & s_wready;
            if (!rst) begin
                if (m_awvalid && m_awready) begin
                    if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                    else check("m_aw", m_aw, exp_aw.pop_front());
                end
                if (m_wvalid && m_wready) begin
                    w_seen++;
                    got_w = {m_wlast, m_wstrb, m_wdata};
                    if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                    else check("m_w", got_w, exp_w.pop_front());
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_aw[i] && aw_q[i].size() > 0) void'(aw_q[i].pop_front());
                if (hs_w[i] && w_q[i].size() > 0) void'(w_q[i].pop_front());
                s_awvalid[i] = (aw_q[i].size() > 0);
                s_aw[i*AWW +: AWW] = (aw_q[i].size() > 0) ? aw_q[i][0] : '0;
                wb = (w_q[i].size() > 0) ? w_q[i][0] : '0;
                s_wvalid[i] = (w_q[i].size() > 0);
                {s_wlast[i], s_wstrb[i*8 +: 8], s_wdata[i*DW +: DW]} = wb;
            end
        end
    end

    initial begin
        logic [AWW-1:0] a [6];
        logic [N-1:0]   gexp [5];
        int             base;
        rst = 1'b1; m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0; s_bready = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_aw", m_aw, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_awready", s_awready, 0);
        check("rst_wready", s_wready, 0);
        check("rst_ptr", dut.w_rr_ptr, 0);
        tick();
        rst = 1'b0;

        // Full-throughput round robin: 0,1,2,3,0
        m_awready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 5; i++) a[i] = mk_aw(4'(i + 1), 32'h1000 * (i + 1), 4'd0);
        aw_q[0].push_back(a[0]); aw_q[1].push_back(a[1]); aw_q[2].push_back(a[2]);
        aw_q[3].push_back(a[3]); aw_q[0].push_back(a[4]);
        for (int i = 0; i < 5; i++) w_q[i % 4].push_back(mk_w(64'hA0 + i, 1'b1));
        exp_aw.push_back({2'd0, a[0]}); exp_aw.push_back({2'd1, a[1]});
        exp_aw.push_back({2'd2, a[2]}); exp_aw.push_back({2'd3, a[3]});
        exp_aw.push_back({2'd0, a[4]});
        for (int i = 0; i < 5; i++) exp_w.push_back(mk_w(64'hA0 + i, 1'b1));
        gexp[0] = 4'b0001; gexp[1] = 4'b0010; gexp[2] = 4'b0100; gexp[3] = 4'b1000; gexp[4] = 4'b0001;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_grant", s_awready, gexp[k]);
        end
        drain();

        // W order: M2 len=3 granted before M0, M0 W waits
        a[0] = mk_aw(4'h2, 32'h2200, 4'd3);
        a[1] = mk_aw(4'h5, 32'h0500, 4'd0);
        aw_q[2].push_back(a[0]); aw_q[0].push_back(a[1]);
        w_q[0].push_back(mk_w(64'hB00, 1'b1));
        exp_aw.push_back({2'd2, a[0]}); exp_aw.push_back({2'd0, a[1]});
        for (int i = 0; i < 4; i++) exp_w.push_back(mk_w(64'hC0 + i, i == 3));
        exp_w.push_back(mk_w(64'hB00, 1'b1));
        repeat (5) tick();
        @(negedge clk);
        check("stall_wready", s_wready, 4'b0100);
        check("stall_wvalid", m_wvalid, 0);
        tick();
        for (int i = 0; i < 4; i++) w_q[2].push_back(mk_w(64'hC0 + i, i == 3));
        drain();

        // Order FIFO full: 5th AW waits for a WLAST pop
        m_wready = 1'b0;
        for (int i = 0; i < 5; i++) a[i] = mk_aw(4'(8 + i), 32'h3000 + i, 4'd0);
        aw_q[1].push_back(a[0]); aw_q[2].push_back(a[1]); aw_q[3].push_back(a[2]);
        aw_q[0].push_back(a[3]); aw_q[1].push_back(a[4]);
        w_q[1].push_back(mk_w(64'hD1, 1'b1)); w_q[2].push_back(mk_w(64'hD2, 1'b1));
        w_q[3].push_back(mk_w(64'hD3, 1'b1)); w_q[0].push_back(mk_w(64'hD0, 1'b1));
        w_q[1].push_back(mk_w(64'hD5, 1'b1));
        exp_aw.push_back({2'd1, a[0]}); exp_aw.push_back({2'd2, a[1]});
        exp_aw.push_back({2'd3, a[2]}); exp_aw.push_back({2'd0, a[3]});
        exp_aw.push_back({2'd1, a[4]});
        exp_w.push_back(mk_w(64'hD1, 1'b1)); exp_w.push_back(mk_w(64'hD2, 1'b1));
        exp_w.push_back(mk_w(64'hD3, 1'b1)); exp_w.push_back(mk_w(64'hD0, 1'b1));
        exp_w.push_back(mk_w(64'hD5, 1'b1));
        gexp[0] = 4'b0010; gexp[1] = 4'b0100; gexp[2] = 4'b1000; gexp[3] = 4'b0001;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fill_grant", s_awready, gexp[k]);
        end
        @(negedge clk); check("full_block0", s_awready, 0);
        @(negedge clk); check("full_block1", s_awready, 0);
        tick();
        m_wready = 1'b1;
        @(negedge clk); check("pop_cycle", s_awready, 0);
        @(negedge clk); check("after_pop", s_awready, 4'b0010);
        drain();

        // B routing by ID prefix
        tick();
        m_bvalid = 1'b1; m_bid = {2'd1, 4'hA}; m_bresp = AXI3_RESP_OKAY; s_bready = 4'b0000;
        @(negedge clk);
        check("b_valid1", s_bvalid, 4'b0010);
        check("b_id1", s_bid, 4'hA);
        check("b_ready_lo", m_bready, 0);
        tick();
        s_bready = 4'b0010;
        @(negedge clk); check("b_ready_hi", m_bready, 1);
        tick();
        m_bid = {2'd3, 4'h5}; m_bresp = AXI3_RESP_SLVERR;
        @(negedge clk);
        check("b_valid3", s_bvalid, 4'b1000);
        check("b_id3", s_bid, 4'h5);
        check("b_resp3", s_bresp, AXI3_RESP_SLVERR);
        check("b_ready_other", m_bready, 0);
        tick();
        s_bready = 4'b1000;
        @(negedge clk); check("b_ready3", m_bready, 1);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        @(negedge clk); check("b_idle", s_bvalid, 0);

        // Downstream AW backpressure holds the register
        tick();
        m_awready = 1'b0;
        a[0] = mk_aw(4'h3, 32'h4000, 4'd0);
        a[1] = mk_aw(4'h4, 32'h4100, 4'd0);
        aw_q[3].push_back(a[0]); aw_q[3].push_back(a[1]);
        w_q[3].push_back(mk_w(64'hE0, 1'b1)); w_q[3].push_back(mk_w(64'hE1, 1'b1));
        exp_aw.push_back({2'd3, a[0]}); exp_aw.push_back({2'd3, a[1]});
        exp_w.push_back(mk_w(64'hE0, 1'b1)); exp_w.push_back(mk_w(64'hE1, 1'b1));
        tick();
        @(negedge clk); check("bp_grant", s_awready, 4'b1000);
        @(negedge clk); check("bp_hold", s_awready, 0);
        check("bp_awvalid", m_awvalid, 1);
        check("bp_aw", m_aw, {2'd3, a[0]});
        tick();
        m_awready = 1'b1;
        @(negedge clk); check("bp_release", s_awready, 4'b1000);
        drain();

        // Reset during a 16-beat burst
        a[0] = mk_aw(4'h7, 32'h8000, 4'd15);
        aw_q[0].push_back(a[0]);
        exp_aw.push_back({2'd0, a[0]});
        for (int i = 0; i < 16; i++) begin
            w_q[0].push_back(mk_w(64'hF00 + i, i == 15));
            exp_w.push_back(mk_w(64'hF00 + i, i == 15));
        end
        base = w_seen;
        for (int k = 0; k < 100; k++) begin
            if (w_seen - base >= 7) break;
            tick();
        end
        check("beats_before_rst", w_seen - base, 7);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            aw_q[i].delete();
            w_q[i].delete();
        end
        exp_aw.delete();
        exp_w.delete();
        tick();
        @(negedge clk);
        check("mid_rst_awvalid", m_awvalid, 0);
        check("mid_rst_wvalid", m_wvalid, 0);
        check("mid_rst_fifo", dut.r_cnt_q, 0);
        check("mid_rst_ptr", dut.w_rr_ptr, 0);
        check("mid_rst_wready", s_wready, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
